// File: rtl/dds_cfg_loader.sv
// dds_cfg_loader: collects N_CH channel tuples and serially loads them into the DDS core
module dds_cfg_loader #(
  parameter int SIG_WIDTH = 16,
  parameter int N_CH = 8,
  parameter logic [8:0] THETAS = 9'd0,
  parameter logic [8:0] DELTAS = 9'd1,
  parameter logic [8:0] AMPLS = 9'd2,
  parameter logic [8:0] NOP_ADDR = 9'h1FF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_run_enable,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [SIG_WIDTH-1:0] s_theta,
  input  logic [SIG_WIDTH-1:0] s_delta,
  input  logic [SIG_WIDTH-1:0] s_ampl,
  output logic                 o_dds_rst,
  output logic                 o_dds_start,
  output logic [8:0]           o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int CW = $clog2(N_CH);
  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, WR_THETA, WR_DELTA, WR_AMPL, RUN} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt, inc;
  logic last, acc;
  logic [SIG_WIDTH-1:0] th_buf [N_CH];
  logic [SIG_WIDTH-1:0] dl_buf [N_CH];
  logic [SIG_WIDTH-1:0] am_buf [N_CH];
  assign last = cnt == CW'(N_CH - 1);
  assign acc = s_valid && s_ready;
  assign inc = last ? '0 : cnt + CW'(1);
  always_comb begin
    nstate = state;
    ncnt = cnt;
    case (state)
      IDLE:     nstate = i_load ? CLEAR : IDLE;
      CLEAR:    begin nstate = COLLECT; ncnt = '0; end
      COLLECT:  begin ncnt = acc ? inc : cnt; nstate = acc && last ? WR_THETA : COLLECT; end
      WR_THETA: begin ncnt = inc; nstate = last ? WR_DELTA : WR_THETA; end
      WR_DELTA: begin ncnt = inc; nstate = last ? WR_AMPL : WR_DELTA; end
      WR_AMPL:  begin ncnt = inc; nstate = last ? RUN : WR_AMPL; end
      RUN:      nstate = i_load ? CLEAR : RUN;
      default:  nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      s_ready <= 1'b0;
      o_dds_rst <= 1'b0;
      o_dds_start <= 1'b0;
      o_dds_addrs <= NOP_ADDR;
      o_dds_fifo_data <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      s_ready <= nstate == COLLECT;
      o_dds_rst <= nstate == CLEAR;
      o_dds_start <= nstate == RUN && i_run_enable;
      o_busy <= nstate != IDLE && nstate != RUN;
      o_done <= nstate == RUN && state != RUN;
      o_dds_addrs <= nstate == WR_THETA ? THETAS : nstate == WR_DELTA ? DELTAS : nstate == WR_AMPL ? AMPLS : NOP_ADDR;
      o_dds_fifo_data <= nstate == WR_THETA ? th_buf[ncnt] : nstate == WR_DELTA ? dl_buf[ncnt] : nstate == WR_AMPL ? am_buf[ncnt] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      th_buf[cnt] <= s_theta;
      dl_buf[cnt] <= s_delta;
      am_buf[cnt] <= s_ampl;
    end
  end
endmodule

// File: tb/tb_dds_cfg_loader.sv
// tb_dds_cfg_loader: scoreboard bench for the DDS configuration loader
module tb_dds_cfg_loader;
  localparam int W = 16;
  localparam int N = 4;
  localparam logic [8:0] NOP = 9'h1FF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_load = 1'b0;
  logic i_run_enable = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [W-1:0] s_theta = '0;
  logic [W-1:0] s_delta = '0;
  logic [W-1:0] s_ampl = '0;
  logic o_dds_rst, o_dds_start, o_busy, o_done;
  logic [8:0] o_dds_addrs;
  logic [W-1:0] o_dds_fifo_data;
  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [W-1:0] qt [$];
  logic [W-1:0] qd [$];
  logic [W-1:0] qa [$];
  logic [W-1:0] th [N];
  logic [W-1:0] dl [N];
  logic [W-1:0] am [N];
  dds_cfg_loader #(.SIG_WIDTH(W), .N_CH(N)) dut (
    .clk(clk),
    .rst(rst),
    .i_load(i_load),
    .i_run_enable(i_run_enable),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_theta(s_theta),
    .s_delta(s_delta),
    .s_ampl(s_ampl),
    .o_dds_rst(o_dds_rst),
    .o_dds_start(o_dds_start),
    .o_dds_addrs(o_dds_addrs),
    .o_dds_fifo_data(o_dds_fifo_data),
    .o_busy(o_busy),
    .o_done(o_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_start_excl", 32'(o_dds_rst && o_dds_start), 0);
      chk("start_at_nop", 32'(o_dds_start && o_dds_addrs != NOP), 0);
      chk("ready_in_busy", 32'(s_ready && !o_busy), 0);
      if (s_valid && s_ready) acc_cnt++;
      if (o_done) done_cnt++;
      if (o_dds_addrs == 9'd0) chk("theta_data", 32'(o_dds_fifo_data), qt.size() > 0 ? 32'(qt.pop_front()) : 32'hDEAD0000);
      else if (o_dds_addrs == 9'd1) chk("delta_data", 32'(o_dds_fifo_data), qd.size() > 0 ? 32'(qd.pop_front()) : 32'hDEAD0000);
      else if (o_dds_addrs == 9'd2) chk("ampl_data", 32'(o_dds_fifo_data), qa.size() > 0 ? 32'(qa.pop_front()) : 32'hDEAD0000);
      else chk("nop_word", 32'({o_dds_addrs, o_dds_fifo_data}), 32'({NOP, 16'h0}));
    end
  end
  task automatic send(input int i, input int gap);
    int t = 0;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_theta = th[i];
    s_delta = dl[i];
    s_ampl = am[i];
    qt.push_back(th[i]);
    qd.push_back(dl[i]);
    qa.push_back(am[i]);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", t, 0);
    @(negedge clk);
  endtask
  task automatic run_load(input int gap, input bit poke);
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    i_run_enable = 1'b0;
    acc_cnt = 0;
    done_cnt = 0;
    chk("clear_rst", 32'(o_dds_rst), 1);
    chk("clear_busy", 32'(o_busy), 1);
    chk("clear_start", 32'(o_dds_start), 0);
    chk("clear_ready", 32'(s_ready), 0);
    for (int i = 0; i < N; i++) send(i, i > 0 ? gap : 0);
    s_valid = 1'b0;
    for (int c = 0; c < 3 * N; c++) begin
      chk("wr_addr", 32'(o_dds_addrs), c / N);
      chk("wr_busy", 32'(o_busy), 1);
      i_load = poke && c == N + 1;
      @(negedge clk);
    end
    i_load = 1'b0;
    chk("done_pulse", 32'(o_done), 1);
    chk("run_busy", 32'(o_busy), 0);
    chk("run_addr", 32'(o_dds_addrs), 32'(NOP));
    chk("run_start_off", 32'(o_dds_start), 0);
    chk("run_ready", 32'(s_ready), 0);
    i_run_enable = 1'b1;
    @(negedge clk);
    chk("run_start_on", 32'(o_dds_start), 1);
    chk("done_single", 32'(o_done), 0);
    @(negedge clk);
    chk("accept_count", acc_cnt, N);
    chk("done_count", done_cnt, 1);
    chk("queues_drained", qt.size() + qd.size() + qa.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({o_dds_addrs, o_dds_fifo_data, o_dds_rst, o_dds_start, s_ready, o_busy, o_done}), 32'({NOP, 16'h0, 5'b0}));
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({o_dds_addrs, o_dds_fifo_data, o_dds_rst, o_dds_start, s_ready, o_busy, o_done}), 32'({NOP, 16'h0, 5'b0}));
    end
    th = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    dl = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    am = '{16'h7FFF, 16'h4000, 16'h2000, 16'h1000};
    run_load(0, 1'b0);
    run_load(3, 1'b0);
    run_load(0, 1'b1);
    chk("run_start_before_reload", 32'(o_dds_start), 1);
    for (int i = 0; i < N; i++) begin
      th[i] = 16'hA000 + 16'(i * 16'h0111);
      dl[i] = 16'h0B00 + 16'(i * 16'h0021);
      am[i] = 16'h5000 - 16'(i * 16'h0333);
    end
    run_load(0, 1'b0);
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    send(0, 0);
    send(1, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(s_ready), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_addr", 32'(o_dds_addrs), 32'(NOP));
    rst = 1'b0;
    qt.delete();
    qd.delete();
    qa.delete();
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", 32'({s_ready, o_busy, o_dds_rst}), 0);
    for (int i = 0; i < N; i++) begin
      th[i] = 16'h1234 + 16'(i);
      dl[i] = 16'h0040 << i;
      am[i] = 16'hF00F ^ 16'(i << 4);
    end
    run_load(1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
